// File: rtl/sram_seq_pkg.sv
// Shared constants and helpers for the asynchronous-SRAM access sequencer:
// state encodings, wait-counter sizing and parameter legality.
package sram_seq_pkg;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_RD   = 3'd1;
  localparam logic [2:0] ST_WS   = 3'd2;
  localparam logic [2:0] ST_WP   = 3'd3;
  localparam logic [2:0] ST_WH   = 3'd4;
  localparam logic [2:0] ST_TURN = 3'd5;
  localparam logic [2:0] ST_DONE = 3'd6;

  // Counter must hold the largest wait value; never narrower than one bit.
  function automatic int cnt_w(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return ($clog2(m + 1) < 1) ? 1 : $clog2(m + 1);
  endfunction

  function automatic bit params_ok(input int data_w, input int rw,
                                   input int ww, input int tc);
    return (data_w >= 8) && (data_w % 8 == 0) &&
           (rw >= 0) && (rw <= 15) &&
           (ww >= 0) && (ww <= 15) &&
           (tc >= 0) && (tc <= 3);
  endfunction

endpackage

// File: rtl/sram_access_seq_if.sv
// Requester-side handshake bundle: single-word request in, completion pulses
// and read data out.
interface sram_access_seq_if #(
  parameter int ADDR_W = 20,
  parameter int DATA_W = 16
);
  localparam int NB = DATA_W / 8;

  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [NB-1:0]     be;
  logic              ready;
  logic [DATA_W-1:0] rdata;
  logic              rvalid;
  logic              wdone;
  logic              busy;

  modport master (
    output req, we, addr, wdata, be,
    input  ready, rdata, rvalid, wdone, busy
  );

  modport slave (
    input  req, we, addr, wdata, be,
    output ready, rdata, rvalid, wdone, busy
  );

endinterface

// File: rtl/sram_wait_ctr.sv
// Loadable down-counter that times each sequencer state; it saturates at
// zero and the zero flag tells the FSM the current state is finished.
module sram_wait_ctr #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/sram_access_seq.sv
// Turns single-word requests into timed active-low SRAM strobe sequences with
// configurable read/write wait states and post-access bus turnaround.
module sram_access_seq
  import sram_seq_pkg::*;
#(
  parameter int ADDR_W     = 20,
  parameter int DATA_W     = 16,
  parameter int READ_WAIT  = 1,
  parameter int WRITE_WAIT = 1,
  parameter int TURN_CYC   = 1
) (
  input  logic                 Clk,
  input  logic                 Reset,
  sram_access_seq_if.slave     bus,
  output logic [ADDR_W-1:0]    A,
  output logic                 CE_N,
  output logic                 OE_N,
  output logic                 WE_N,
  output logic [DATA_W/8-1:0]  BE_N,
  output logic [DATA_W-1:0]    Data_out,
  output logic                 Data_oe,
  input  logic [DATA_W-1:0]    Data_in
);

  localparam int NB = DATA_W / 8;
  localparam int CW = cnt_w(READ_WAIT, WRITE_WAIT, TURN_CYC);

  localparam logic [CW-1:0] RD_LD   = CW'(READ_WAIT);
  localparam logic [CW-1:0] WP_LD   = CW'(WRITE_WAIT);
  localparam logic [CW-1:0] TURN_LD = (TURN_CYC > 0) ? CW'(TURN_CYC - 1) : '0;
  localparam logic [2:0]    AFTER_ACC = (TURN_CYC > 0) ? ST_TURN : ST_IDLE;

  if (!params_ok(DATA_W, READ_WAIT, WRITE_WAIT, TURN_CYC)) begin : g_bad_params
    $error("sram_access_seq: illegal parameter set");
  end

  logic [2:0]        state;
  logic [2:0]        state_nxt;
  logic              ready;
  logic              accept;
  logic              be_zero;
  logic              ld;
  logic [CW-1:0]     ld_val;
  logic              zero;
  logic              rd_end;
  logic              in_acc_nxt;
  logic [NB-1:0]     be_l;
  logic [NB-1:0]     be_nxt;
  logic [DATA_W-1:0] lane_mask;
  logic [DATA_W-1:0] rdata;
  logic              rvalid;
  logic              wdone;

  assign ready   = (state == ST_IDLE) & ~Reset;
  assign accept  = bus.req & ready;
  assign be_zero = (bus.be == '0);
  assign rd_end  = (state == ST_RD) & zero;

  sram_wait_ctr #(.W(CW)) u_wait_ctr (
    .clk      (Clk),
    .rst      (Reset),
    .load     (ld),
    .load_val (ld_val),
    .dec      (~ld),
    .zero     (zero)
  );

  // Each timed state loads the counter on entry and leaves when it reaches zero.
  always_comb begin
    state_nxt = state;
    ld        = 1'b0;
    ld_val    = '0;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          if (be_zero) begin
            state_nxt = ST_DONE;
          end else if (bus.we) begin
            state_nxt = ST_WS;
          end else begin
            state_nxt = ST_RD;
            ld        = 1'b1;
            ld_val    = RD_LD;
          end
        end
      end
      ST_RD: begin
        if (zero) begin
          state_nxt = AFTER_ACC;
          ld        = 1'b1;
          ld_val    = TURN_LD;
        end
      end
      ST_WS: begin
        state_nxt = ST_WP;
        ld        = 1'b1;
        ld_val    = WP_LD;
      end
      ST_WP: begin
        if (zero) state_nxt = ST_WH;
      end
      ST_WH: begin
        state_nxt = AFTER_ACC;
        ld        = 1'b1;
        ld_val    = TURN_LD;
      end
      ST_TURN: begin
        if (zero) state_nxt = ST_IDLE;
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    lane_mask = '0;
    for (int i = 0; i < NB; i++) begin
      lane_mask[8*i +: 8] = {8{be_l[i]}};
    end
  end

  assign in_acc_nxt = (state_nxt == ST_RD) || (state_nxt == ST_WS) ||
                      (state_nxt == ST_WP) || (state_nxt == ST_WH);
  assign be_nxt     = accept ? bus.be : be_l;

  // Strobes are registered from the next state so they change cleanly on the edge.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state    <= ST_IDLE;
      A        <= '0;
      Data_out <= '0;
      be_l     <= '0;
      CE_N     <= 1'b1;
      OE_N     <= 1'b1;
      WE_N     <= 1'b1;
      BE_N     <= '1;
      Data_oe  <= 1'b0;
      rdata    <= '0;
      rvalid   <= 1'b0;
      wdone    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        A        <= bus.addr;
        Data_out <= bus.wdata;
        be_l     <= bus.be;
      end
      CE_N    <= ~in_acc_nxt;
      OE_N    <= ~(state_nxt == ST_RD);
      WE_N    <= ~(state_nxt == ST_WP);
      BE_N    <= in_acc_nxt ? ~be_nxt : '1;
      Data_oe <= (state_nxt == ST_WS) || (state_nxt == ST_WP) ||
                 (state_nxt == ST_WH);
      rvalid  <= rd_end | (accept & be_zero & ~bus.we);
      wdone   <= (state == ST_WH) | (accept & be_zero & bus.we);
      if (rd_end) begin
        rdata <= Data_in & lane_mask;
      end else if (accept & be_zero & ~bus.we) begin
        rdata <= '0;
      end
    end
  end

  assign bus.ready  = ready;
  assign bus.busy   = ~ready;
  assign bus.rdata  = rdata;
  assign bus.rvalid = rvalid;
  assign bus.wdone  = wdone;

endmodule

// File: tb/tb_sram_access_seq.sv
// Directed bench for sram_access_seq: a default instance and one with
// READ_WAIT=3, TURN_CYC=0, driven from a vector table plus corner sequences.
module tb_sram_access_seq;

  typedef struct {
    logic        we;
    logic [19:0] addr;
    logic [15:0] wdata;
    logic [1:0]  be;
    logic [15:0] din;
    logic        dsel;
    int          lat;
    logic [15:0] rdata;
    int          rdy;
    int          oe;
    int          wen;
    int          doe;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        sel;
  logic        req_d;
  logic        we_d;
  logic [19:0] addr_d;
  logic [15:0] wdata_d;
  logic [1:0]  be_d;
  logic [15:0] din;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sram_access_seq_if #(.ADDR_W(20), .DATA_W(16)) bus0 ();
  sram_access_seq_if #(.ADDR_W(20), .DATA_W(16)) bus1 ();

  assign bus0.req   = req_d & ~sel;
  assign bus0.we    = we_d;
  assign bus0.addr  = addr_d;
  assign bus0.wdata = wdata_d;
  assign bus0.be    = be_d;
  assign bus1.req   = req_d & sel;
  assign bus1.we    = we_d;
  assign bus1.addr  = addr_d;
  assign bus1.wdata = wdata_d;
  assign bus1.be    = be_d;

  logic [19:0] a0, a1;
  logic        ce0, ce1, oe0, oe1, wen0, wen1, doe0, doe1;
  logic [1:0]  ben0, ben1;
  logic [15:0] dout0, dout1;

  sram_access_seq dut0 (
    .Clk(clk), .Reset(rst), .bus(bus0),
    .A(a0), .CE_N(ce0), .OE_N(oe0), .WE_N(wen0), .BE_N(ben0),
    .Data_out(dout0), .Data_oe(doe0), .Data_in(din)
  );

  sram_access_seq #(.READ_WAIT(3), .TURN_CYC(0)) dut1 (
    .Clk(clk), .Reset(rst), .bus(bus1),
    .A(a1), .CE_N(ce1), .OE_N(oe1), .WE_N(wen1), .BE_N(ben1),
    .Data_out(dout1), .Data_oe(doe1), .Data_in(din)
  );

  logic        m_ready, m_rvalid, m_wdone, m_ce, m_oe, m_wen, m_doe;
  logic [15:0] m_rdata, m_dout;
  logic [19:0] m_a;
  logic [1:0]  m_ben;

  assign m_ready  = sel ? bus1.ready  : bus0.ready;
  assign m_rvalid = sel ? bus1.rvalid : bus0.rvalid;
  assign m_wdone  = sel ? bus1.wdone  : bus0.wdone;
  assign m_rdata  = sel ? bus1.rdata  : bus0.rdata;
  assign m_ce     = sel ? ce1   : ce0;
  assign m_oe     = sel ? oe1   : oe0;
  assign m_wen    = sel ? wen1  : wen0;
  assign m_doe    = sel ? doe1  : doe0;
  assign m_dout   = sel ? dout1 : dout0;
  assign m_a      = sel ? a1    : a0;
  assign m_ben    = sel ? ben1  : ben0;

  task automatic check_output(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_ready(input string name, output bit ok);
    int n;
    n  = 0;
    ok = 1'b1;
    while (!m_ready) begin
      @(negedge clk);
      n++;
      if (n > 40) begin
        check_output({name, "_ready_timeout"}, 32'd0, 32'd1);
        ok = 1'b0;
        return;
      end
    end
  endtask

  // Cycle 0 is the cycle whose edge accepts the request; samples are on negedges.
  task automatic apply_stimulus(input int idx, input vec_t v);
    int lat, npulse, wrong, rdy, oe, wen, doe, ce, viol;
    logic [15:0] rd;
    bit ok;
    string nm;
    bit pulse, other;
    nm = $sformatf("vec%0d", idx);
    lat = -1; npulse = 0; wrong = 0; rdy = -1;
    oe = 0; wen = 0; doe = 0; ce = 0; viol = 0; rd = '0;
    @(negedge clk);
    sel = v.dsel; we_d = v.we; addr_d = v.addr; wdata_d = v.wdata;
    be_d = v.be; din = v.din; req_d = 1'b1;
    wait_ready(nm, ok);
    if (!ok) begin
      req_d = 1'b0;
      return;
    end
    for (int cyc = 1; cyc <= 15; cyc++) begin
      @(negedge clk);
      req_d = 1'b0;
      pulse = v.we ? m_wdone : m_rvalid;
      other = v.we ? m_rvalid : m_wdone;
      if (pulse) begin
        npulse++;
        if (lat < 0) begin
          lat = cyc;
          rd  = m_rdata;
        end
      end
      if (other) wrong++;
      if (!m_ce) ce++;
      if (!m_oe && !m_ce) oe++;
      if (!m_wen) wen++;
      if (m_doe) doe++;
      if (!m_oe && m_doe) viol++;
      if (!m_wen && (m_ce || !m_doe || m_a != v.addr || m_dout != v.wdata ||
                     m_ben != ~v.be)) viol++;
      if (!m_ce && (m_a != v.addr || m_ben != ~v.be)) viol++;
      if (m_ready && rdy < 0) rdy = cyc;
    end
    check_output({nm, "_latency"}, lat, v.lat);
    check_output({nm, "_pulse_count"}, npulse, 1);
    check_output({nm, "_wrong_pulse"}, wrong, 0);
    if (!v.we) check_output({nm, "_rdata"}, {16'h0, rd}, {16'h0, v.rdata});
    check_output({nm, "_ready_return"}, rdy, v.rdy);
    check_output({nm, "_oe_cycles"}, oe, v.oe);
    check_output({nm, "_we_cycles"}, wen, v.wen);
    check_output({nm, "_doe_cycles"}, doe, v.doe);
    check_output({nm, "_ce_cycles"}, ce, v.we ? v.doe : v.oe);
    check_output({nm, "_invariants"}, viol, 0);
  endtask

  vec_t vecs[8];

  initial begin
    int rv, acc2, wd, nrv, nwd, viol;
    bit ok;

    vecs[0] = '{1'b0, 20'h00123, 16'h0000, 2'b11, 16'hBEEF, 1'b0, 3, 16'hBEEF, 4, 2, 0, 0};
    vecs[1] = '{1'b1, 20'h0004A, 16'h1234, 2'b01, 16'h0000, 1'b0, 5, 16'h0000, 6, 0, 2, 4};
    vecs[2] = '{1'b0, 20'h00200, 16'h0000, 2'b10, 16'hBEEF, 1'b0, 3, 16'hBE00, 4, 2, 0, 0};
    vecs[3] = '{1'b1, 20'h00300, 16'hABCD, 2'b00, 16'h0000, 1'b0, 1, 16'h0000, 2, 0, 0, 0};
    vecs[4] = '{1'b0, 20'h00301, 16'h0000, 2'b00, 16'hBEEF, 1'b0, 1, 16'h0000, 2, 0, 0, 0};
    vecs[5] = '{1'b0, 20'h00055, 16'h0000, 2'b11, 16'h5A5A, 1'b1, 5, 16'h5A5A, 5, 4, 0, 0};
    vecs[6] = '{1'b1, 20'h00066, 16'hCAFE, 2'b10, 16'h0000, 1'b1, 5, 16'h0000, 5, 0, 2, 4};
    vecs[7] = '{1'b0, 20'h00077, 16'h0000, 2'b01, 16'h1234, 1'b1, 5, 16'h0034, 5, 4, 0, 0};

    rst = 1'b1; sel = 1'b0; req_d = 1'b0; we_d = 1'b0;
    addr_d = '0; wdata_d = '0; be_d = '0; din = '0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check_output("rst_strobes0", {ce0, oe0, wen0, doe0}, 4'b1110);
    check_output("rst_ben0", ben0, 2'b11);
    check_output("rst_pulses0", {bus0.rvalid, bus0.wdone}, 2'b00);
    check_output("rst_a_rdata0", {a0, bus0.rdata}, 36'h0);
    check_output("rst_strobes1", {ce1, oe1, wen1, doe1, ben1}, 6'b111011);
    rst = 1'b0;
    @(negedge clk);
    check_output("rst_ready", {bus0.ready, bus1.ready, bus0.busy}, 3'b110);

    for (int i = 0; i < 8; i++) apply_stimulus(i, vecs[i]);

    // Back-to-back: req stays high; write must be accepted the cycle ready returns.
    @(negedge clk);
    sel = 1'b0; we_d = 1'b0; addr_d = 20'h00123; be_d = 2'b11;
    din = 16'hBEEF; req_d = 1'b1;
    rv = -1; acc2 = -1; wd = -1; nrv = 0; nwd = 0; viol = 0;
    wait_ready("b2b", ok);
    if (ok) begin
      for (int cyc = 1; cyc <= 14; cyc++) begin
        @(negedge clk);
        if (cyc == 1) begin
          we_d = 1'b1; addr_d = 20'h0004A; wdata_d = 16'h1234; be_d = 2'b01;
        end
        if (acc2 >= 0 && cyc == acc2 + 1) req_d = 1'b0;
        if (m_rvalid) begin nrv++; if (rv < 0) rv = cyc; end
        if (m_wdone) begin nwd++; if (wd < 0) wd = cyc; end
        if (m_ready && acc2 < 0) acc2 = cyc;
        if (!m_oe && m_doe) viol++;
      end
      check_output("b2b_rvalid_cycle", rv, 3);
      check_output("b2b_second_accept", acc2, 4);
      check_output("b2b_wdone_cycle", wd, 9);
      check_output("b2b_pulse_counts", {nrv[7:0], nwd[7:0]}, 16'h0101);
      check_output("b2b_oe_vs_doe", viol, 0);
    end
    req_d = 1'b0;

    // Reset in the WE pulse: strobes release at the next edge, no wdone.
    @(negedge clk);
    sel = 1'b0; we_d = 1'b1; addr_d = 20'h00077; wdata_d = 16'h5555;
    be_d = 2'b11; req_d = 1'b1;
    wait_ready("rstwp", ok);
    if (ok) begin
      @(negedge clk);
      req_d = 1'b0;
      @(negedge clk);
      check_output("rstwp_in_wp", {m_wen, m_ce, m_doe}, 3'b001);
      rst = 1'b1;
      @(negedge clk);
      check_output("rstwp_released", {m_wen, m_ce, m_doe, m_ben}, 5'b11011);
      rst = 1'b0;
      nwd = 0;
      for (int cyc = 0; cyc < 8; cyc++) begin
        @(negedge clk);
        if (m_wdone) nwd++;
      end
      check_output("rstwp_no_wdone", nwd, 0);
      check_output("rstwp_ready_after", m_ready, 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/sram_access_seq.md
Name: sram_access_seq

Overview:
- Parametrised sequencer that turns single-word CPU/ISDU memory requests into timed asynchronous-SRAM strobe sequences (CE/OE/WE/byte-lane enables, all active-low).
- Sits between the datapath/control pair and the Mem2IO/SRAM path, replacing strobes that the ISDU drives directly.
- Adds configurable read and write wait states, bus turnaround, generic byte lanes, and a ready/valid handshake.

Parameters:
- ADDR_W, 20, address width.
- DATA_W, 16, data width; must be a multiple of 8; lanes NB = DATA_W/8.
- READ_WAIT, 1, extra cycles OE is held beyond the first (0..15).
- WRITE_WAIT, 1, extra cycles WE pulse is held beyond the first (0..15).
- TURN_CYC, 1, idle cycles inserted after every access (0..3).

Ports:
- Clk  in  1  clock
- Reset  in  1  synchronous, active-high reset
- req  in  1  request; held by requester until accepted
- we  in  1  1 = write, 0 = read
- addr  in  ADDR_W  word address
- wdata  in  DATA_W  write data
- be  in  NB  byte enables, active-high, bit i = lane i
- ready  out  1  can accept; accept = req & ready
- rdata  out  DATA_W  registered read data
- rvalid  out  1  one-cycle read-complete pulse
- wdone  out  1  one-cycle write-complete pulse
- busy  out  1  = ~ready
- A  out  ADDR_W  SRAM address
- CE_N, OE_N, WE_N  out  1 each  SRAM strobes, active-low
- BE_N  out  NB  lane enables, active-low (lane1 = UB, lane0 = LB for 16-bit)
- Data_out  out  DATA_W  write data to bus
- Data_oe  out  1  drive enable for Data_out
- Data_in  in  DATA_W  data from bus

Behaviour:
- Clk and Reset: one clock, Clk; Reset is synchronous and active-high.
- Reset values, effective at the first edge with Reset=1:
  - state IDLE; ready=1.
  - CE_N, OE_N, WE_N = 1; BE_N all 1; Data_oe = 0.
  - A, Data_out, rdata = 0; rvalid = wdone = 0.
- Reset mid-access has the same effect: strobes release at that edge and no completion pulse is issued.
- ready is combinational: ready = (state==IDLE) & ~Reset.
- On accept, latch addr, wdata, be and we. req while busy is ignored; no queueing.
- States:
  - IDLE -> RD when accept & ~we & be≠0. RD lasts READ_WAIT+1 cycles.
    - CE_N=0, OE_N=0, BE_N=~be_l, A=addr_l.
    - On the edge ending the last RD cycle: rdata <= Data_in with disabled lanes forced 0; rvalid=1 for the following cycle.
  - IDLE -> WS (1 cycle) when accept & we & be≠0.
    - WS: CE_N=0, WE_N=1, Data_oe=1, A and BE_N valid.
    - WS -> WP, lasting WRITE_WAIT+1 cycles with WE_N=0.
    - WP -> WH (1 cycle): WE_N=1, CE_N=0, Data_oe=1.
    - wdone=1 for the cycle after WH.
  - After RD or WH: TURN for TURN_CYC cycles (all strobes inactive, Data_oe=0), then IDLE. With TURN_CYC=0, go directly to IDLE.
  - rvalid/wdone assert in the first cycle after the access: the first TURN cycle, or IDLE when TURN_CYC=0.
- Latency from the accept edge:
  - rvalid high READ_WAIT+2 cycles later.
  - wdone high WRITE_WAIT+4 cycles later.
  - Next accept possible READ_WAIT+2+TURN_CYC (read) or WRITE_WAIT+4+TURN_CYC (write) cycles after the accept edge.
- be=0 request: accepted, no strobes. The state goes IDLE -> DONE (1 cycle, pulses rvalid with rdata=0, or wdone) -> IDLE; no TURN.
- Invariants:
  - OE_N=0 and Data_oe=1 never in the same cycle.
  - WE_N=0 only while CE_N=0 and A, BE_N and Data_out are stable; these are stable for the whole WS..WH window.
- Wait counter: loadable down-counter, width $clog2(max(READ_WAIT,WRITE_WAIT,TURN_CYC)+1), minimum 1. It is loaded on state entry; the state exits when the counter is 0.
- All outputs except ready/busy are registered.

Decomposition:
- Package sram_seq_pkg:
  - state enum {IDLE, RD, WS, WP, WH, TURN, DONE}.
  - function cnt_w(a,b,c) returning the counter width.
  - Elaboration-time checks on DATA_W%8 and the parameter ranges.
- Sub-module sram_wait_ctr: load value, load strobe, decrement, zero flag.

Test Plan:
- Default parameters. Apply Reset for 2 cycles -> CE_N=OE_N=WE_N=1, BE_N=2'b11, Data_oe=0, ready=1, rvalid=wdone=0.
- Read: addr=20'h00123, be=2'b11, model drives 16'hBEEF.
  - OE_N=CE_N=0 for exactly 2 cycles; BE_N=00.
  - rvalid for 1 cycle, 3 cycles after accept, with rdata=16'hBEEF.
  - ready returns after 1 TURN cycle.
- Write: addr=20'h0004A, wdata=16'h1234, be=2'b01.
  - BE_N=2'b10; Data_oe high 4 cycles; WE_N low exactly 2 cycles, inside the Data_oe window.
  - wdone 5 cycles after accept.
- Back-to-back: req held high, read then write.
  - Second accept occurs exactly when ready reasserts.
  - Assert OE_N=0 & Data_oe=1 never occurs.
- Byte masking: read be=2'b10 with model 16'hBEEF -> rdata=16'hBE00. Separately, a be=0 write -> no strobes, wdone 1 cycle after accept.
- Reset asserted during WP -> WE_N=1, CE_N=1, Data_oe=0 at the next edge; no wdone.
  - Rerun with READ_WAIT=3, TURN_CYC=0 -> rvalid 5 cycles after accept, and ready in the same cycle.
